// File: rtl/bp_me_cce_pending_bits.sv
// bp_me_cce_pending_bits
// Per-CCE table of saturating pending-transaction counters, one per way group.
// Each counter counts the open coherence transactions to its way group.
//   clk_i, reset_i            clock, synchronous active-high reset
//   w_v_i/w_wg_i/w_inc_i/
//   w_clear_i                 one write per cycle: clear, increment or decrement
//   r_v_i/r_wg_i              combinational read port
//   pending_o/count_o         read data (0 when r_v_i=0 or index out of range)
//   w_v_o/w_wg_o/w_val_o      registered trace of the write applied last cycle
//   err_o                     1-cycle pulse: saturate/underflow/illegal index
module bp_me_cce_pending_bits #(
  parameter int num_way_groups_p = 64,
  parameter int width_p          = 3,
  localparam int lg_num_way_groups_lp =
    (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            w_v_i,
  input  logic [lg_num_way_groups_lp-1:0] w_wg_i,
  input  logic                            w_inc_i,
  input  logic                            w_clear_i,
  input  logic                            r_v_i,
  input  logic [lg_num_way_groups_lp-1:0] r_wg_i,
  output logic                            pending_o,
  output logic [width_p-1:0]              count_o,
  output logic                            w_v_o,
  output logic [lg_num_way_groups_lp-1:0] w_wg_o,
  output logic [width_p-1:0]              w_val_o,
  output logic                            err_o
);

  localparam logic [lg_num_way_groups_lp:0] num_wg_lp =
    (lg_num_way_groups_lp+1)'(num_way_groups_p);
  localparam logic [width_p-1:0] max_lp = '1;

  logic [width_p-1:0] cnt_r [num_way_groups_p];

  // Index range checks; only meaningful for non-power-of-2 table sizes.
  logic w_legal, r_legal;
  assign w_legal = ({1'b0, w_wg_i} < num_wg_lp);
  assign r_legal = ({1'b0, r_wg_i} < num_wg_lp);

  // Read returns the pre-write value; no bypass of a same-cycle write.
  always_comb begin
    count_o = '0;
    if (r_v_i && r_legal)
      count_o = cnt_r[r_wg_i];
  end
  assign pending_o = |count_o;

  logic [width_p-1:0] old_val, new_val;
  logic               sat_err;

  always_comb begin
    old_val = '0;
    if (w_legal)
      old_val = cnt_r[w_wg_i];
    new_val = old_val;
    sat_err = 1'b0;
    if (w_clear_i) begin
      new_val = '0;
    end else if (w_inc_i) begin
      if (old_val == max_lp) sat_err = 1'b1;
      else                   new_val = old_val + 1'b1;
    end else begin
      if (old_val == '0) sat_err = 1'b1;
      else               new_val = old_val - 1'b1;
    end
  end

  // An illegal-index write is dropped: not stored, not traced, but flagged.
  logic apply;
  assign apply = w_v_i && w_legal;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_way_groups_p; i++) cnt_r[i] <= '0;
      w_v_o   <= 1'b0;
      w_wg_o  <= '0;
      w_val_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (apply) cnt_r[w_wg_i] <= new_val;
      w_v_o   <= apply;
      w_wg_o  <= apply ? w_wg_i  : '0;
      w_val_o <= apply ? new_val : '0;
      err_o   <= w_v_i && (!w_legal || sat_err);
    end
  end

endmodule

// File: tb/tb_bp_me_cce_pending_bits.sv
module tb_bp_me_cce_pending_bits;
  localparam int NWG = 64;
  localparam int W   = 3;
  localparam int MAXC = (1 << W) - 1;

  logic       clk = 1'b0;
  logic       reset_i, w_v_i, w_inc_i, w_clear_i, r_v_i;
  logic [5:0] w_wg_i, r_wg_i;
  logic       pending_o, w_v_o, err_o;
  logic [2:0] count_o, w_val_o;
  logic [5:0] w_wg_o;

  int checks = 0;
  int errors = 0;
  int model [NWG];

  bp_me_cce_pending_bits #(.num_way_groups_p(NWG), .width_p(W)) dut (
    .clk_i(clk), .reset_i(reset_i), .w_v_i(w_v_i), .w_wg_i(w_wg_i),
    .w_inc_i(w_inc_i), .w_clear_i(w_clear_i), .r_v_i(r_v_i), .r_wg_i(r_wg_i),
    .pending_o(pending_o), .count_o(count_o), .w_v_o(w_v_o), .w_wg_o(w_wg_o),
    .w_val_o(w_val_o), .err_o(err_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full cycle: drive after negedge, check read, clock, check trace.
  task automatic cyc(input bit rst, input bit wv, input int wg, input bit inc,
                     input bit clr, input bit rv, input int rwg);
    int old_v, new_v, exp_cnt;
    bit e;
    reset_i = rst; w_v_i = wv; w_wg_i = 6'(wg); w_inc_i = inc; w_clear_i = clr;
    r_v_i = rv; r_wg_i = 6'(rwg);
    #1;
    exp_cnt = rv ? model[rwg] : 0;
    chk("count", 32'(count_o), exp_cnt);
    chk("pending", 32'(pending_o), (exp_cnt != 0) ? 1 : 0);
    old_v = model[wg];
    if (clr)      begin new_v = 0; e = 0; end
    else if (inc) begin new_v = (old_v == MAXC) ? old_v : old_v + 1; e = (old_v == MAXC); end
    else          begin new_v = (old_v == 0) ? 0 : old_v - 1; e = (old_v == 0); end
    @(posedge clk); #1;
    if (rst) begin
      foreach (model[i]) model[i] = 0;
      chk("rst_w_v", 32'(w_v_o), 0);
      chk("rst_w_wg", 32'(w_wg_o), 0);
      chk("rst_w_val", 32'(w_val_o), 0);
      chk("rst_err", 32'(err_o), 0);
    end else begin
      if (wv) model[wg] = new_v;
      chk("w_v", 32'(w_v_o), wv ? 1 : 0);
      chk("w_wg", 32'(w_wg_o), wv ? wg : 0);
      chk("w_val", 32'(w_val_o), wv ? new_v : 0);
      chk("err", 32'(err_o), (wv && e) ? 1 : 0);
    end
    @(negedge clk);
  endtask

  task automatic rd(input int wg); cyc(0, 0, 0, 0, 0, 1, wg); endtask
  task automatic inc(input int wg); cyc(0, 1, wg, 1, 0, 0, 0); endtask

  initial begin
    foreach (model[i]) model[i] = 0;
    reset_i = 1; w_v_i = 0; w_wg_i = 0; w_inc_i = 0; w_clear_i = 0;
    r_v_i = 0; r_wg_i = 0;
    @(posedge clk); #1;
    chk("init_w_v", 32'(w_v_o), 0);
    chk("init_err", 32'(err_o), 0);
    @(negedge clk);

    for (int i = 0; i < NWG; i++) rd(i);                 // all zero after reset
    for (int i = 0; i < 3; i++) inc(5);                  // trace 1,2,3
    rd(5); rd(4); rd(6);
    for (int i = 0; i < 8; i++) inc(0);                  // saturate at 7
    rd(0);
    cyc(0, 1, 1, 0, 0, 1, 1);                            // underflow on wg 1
    inc(9); inc(9);
    cyc(0, 1, 9, 1, 0, 1, 9);                            // read sees 2
    rd(9);                                               // now 3
    for (int i = 0; i < 5; i++) inc(12);
    cyc(0, 1, 12, 1, 1, 1, 12);                          // clear beats inc
    rd(12);
    for (int i = 0; i < 4; i++) inc(2);
    cyc(1, 1, 2, 1, 0, 1, 2);                            // reset drops write
    rd(2); rd(5);
    inc(3);                                              // first write after reset
    cyc(0, 0, 0, 0, 0, 0, 5);                            // r_v=0 gives 0

    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 99);
      cyc(r < 2, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
          $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
